uart_tx_fifo: RTL and testbench

//  Byte buffer and launch sequencer upstream of the UART transmitter.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_sync_fifo.sv | 44 ++++
 rtl/uart_tx_fifo.sv | 47 ++++
 tb/tb_uart_tx_fifo.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART transmit queue
package uart_pkg;
  typedef enum logic {TXQ_IDLE, TXQ_WAIT_DONE} txq_state_t;
  localparam int UART_TXQ_DEPTH_DEF = 16;
  typedef logic [7:0] uart_byte_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host push and transmitter launch signals; ovf/ovf_clr exist only with UART_TX_FIFO_OVF_EN
interface uart_tx_fifo_if #(parameter int DEPTH = uart_pkg::UART_TXQ_DEPTH_DEF);
  import uart_pkg::*;
  localparam int ADDR_W = $clog2(DEPTH);
  logic wr_en;
  uart_byte_t wr_data;
  logic full;
  logic empty;
  logic [ADDR_W:0] count;
  logic tx_start;
  uart_byte_t tx_data;
  logic tx_busy;
  logic tx_done;
`ifdef UART_TX_FIFO_OVF_EN
  logic ovf;
  logic ovf_clr;
  modport master (output wr_en, wr_data, tx_busy, tx_done, ovf_clr,
                  input full, empty, count, tx_start, tx_data, ovf);
  modport slave (input wr_en, wr_data, tx_busy, tx_done, ovf_clr,
                 output full, empty, count, tx_start, tx_data, ovf);
`else
  modport master (output wr_en, wr_data, tx_busy, tx_done,
                  input full, empty, count, tx_start, tx_data);
  modport slave (input wr_en, wr_data, tx_busy, tx_done,
                 output full, empty, count, tx_start, tx_data);
`endif
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular byte FIFO with registered count/full/empty and combinational head read
module uart_sync_fifo import uart_pkg::*; #(
  parameter int DEPTH = UART_TXQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  uart_byte_t               wr_data,
  input  logic                     pop,
  output uart_byte_t               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int ADDR_W = $clog2(DEPTH);
  uart_byte_t mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0] count_nxt;
  logic push_ok;
  logic pop_ok;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign count_nxt = count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
  assign rd_data = mem[rd_ptr];
  // storage is deliberately unreset; only the pointers define what is valid
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wr_data;
  // pointers advance on accepted transfers; flags are registered copies of the next count
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_nxt;
      full <= count_nxt == (ADDR_W+1)'(DEPTH);
      empty <= count_nxt == '0;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue feeding a UART transmitter one launch at a time; UART_TX_FIFO_OVF_EN adds a sticky overflow flag
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DEPTH = UART_TXQ_DEPTH_DEF
) (
  input logic          clk,
  input logic          reset_n,
  uart_tx_fifo_if.slave bus
);
  txq_state_t state;
  uart_byte_t rd_data;
  logic launch;
  assign launch = state == TXQ_IDLE && !bus.empty && !bus.tx_busy;
  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(bus.wr_en),
    .wr_data(bus.wr_data),
    .pop(launch),
    .rd_data(rd_data),
    .full(bus.full),
    .empty(bus.empty),
    .count(bus.count)
  );
  // launch sequencer: one-cycle tx_start with the head byte, then hold until the transmitter reports done
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= TXQ_IDLE;
      bus.tx_start <= 1'b0;
      bus.tx_data <= '0;
    end else if (state == TXQ_IDLE) begin
      if (launch) begin
        bus.tx_start <= 1'b1;
        bus.tx_data <= rd_data;
        state <= TXQ_WAIT_DONE;
      end
    end else begin
      bus.tx_start <= 1'b0;
      if (bus.tx_done) state <= TXQ_IDLE;
    end
`ifdef UART_TX_FIFO_OVF_EN
  // sticky overflow: any push attempt while full sets it, and a set beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bus.ovf <= 1'b0;
    else if (bus.wr_en && bus.full) bus.ovf <= 1'b1;
    else if (bus.ovf_clr) bus.ovf <= 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo driven by a behavioural transmitter
module tb_uart_tx_fifo;
  import uart_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset_n;
  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  uart_byte_t sb [$];
  int checks = 0;
  int errors = 0;
  int n_launch = 0;
  int push_cyc = -100;
  int done_cyc = -100;
  bit chk_gap = 0;
  bit force_busy = 0;
  int busy_cnt = 0;
  int tx_lat = 20;
  int stray_req = 0;
  int stray_seen = 0;
  logic prev_start = 1'b0;
  assign bus.tx_busy = force_busy || busy_cnt > 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // monitor: every launch pops the scoreboard and checks data, pulse width and launch latency
  always @(negedge clk) begin
    if (reset_n && bus.tx_start) begin
      n_launch++;
      chk("start_pulse_width", int'(prev_start), 0);
      if (chk_gap) chk("launch_gap", cyc - (push_cyc > done_cyc ? push_cyc : done_cyc), 2);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_launch got %0h want no launch at cycle %0d", bus.tx_data, cyc);
      end else chk("tx_data", int'(bus.tx_data), int'(sb.pop_front()));
    end
    prev_start = bus.tx_start;
  end

  // behavioural transmitter: busy for tx_lat cycles after each launch, then a one-cycle done
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (!reset_n) busy_cnt = 0;
      else if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        bus.tx_done = 1'b1;
      end else begin
        if (busy_cnt == 1) begin
          busy_cnt = 0;
          bus.tx_done = 1'b1;
          done_cyc = cyc;
        end else if (busy_cnt > 1) busy_cnt--;
        if (bus.tx_start) busy_cnt = tx_lat;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit exp_tx);
    bus.wr_en = 1'b1;
    bus.wr_data = b;
    if (exp_tx) sb.push_back(b);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((sb.size() != 0 || bus.tx_busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s_timeout got %0d pending want 0 after %0d cycles", name, sb.size(), max);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    reset_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
`ifdef UART_TX_FIFO_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_tx_start", int'(bus.tx_start), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_ovf", int'(bus.ovf), 0);
`endif
    chk_gap = 1;
    push_cyc = cyc;
    push(8'hA5, 1);
    chk("t2_count_after_push", int'(bus.count), 1);
    @(negedge clk);
    chk("t2_tx_start", int'(bus.tx_start), 1);
    chk("t2_count_after_launch", int'(bus.count), 0);
    drain("t2", 100);
    chk("t2_launches", n_launch, 1);
    push_cyc = cyc;
    push(8'h01, 1);
    push(8'h02, 1);
    push(8'h03, 1);
    drain("t3", 200);
    chk("t3_launches", n_launch, 4);
    chk_gap = 0;
    tx_lat = 4;
    force_busy = 1;
    base = n_launch;
    for (int i = 0; i < DEPTH + 2; i++) push(8'(i), i < DEPTH);
    chk("t4_full", int'(bus.full), 1);
    chk("t4_count", int'(bus.count), DEPTH);
    chk("t4_empty", int'(bus.empty), 0);
    chk("t4_stalled", n_launch - base, 0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("t4_ovf_set", int'(bus.ovf), 1);
    bus.ovf_clr = 1'b1;
    push(8'h12, 0);
    bus.ovf_clr = 1'b0;
    chk("t4_ovf_set_wins", int'(bus.ovf), 1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("t4_ovf_clr", int'(bus.ovf), 0);
`endif
    force_busy = 0;
    drain("t4", 400);
    chk("t4_launches", n_launch - base, DEPTH);
    force_busy = 1;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 1);
    chk("t5_full", int'(bus.full), 1);
    force_busy = 0;
    push(8'h3F, 0);
    chk("t5_push_pop_full_count", int'(bus.count), DEPTH - 1);
    drain("t5a", 400);
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1);
    drain("t5b", 200);
    chk("t5_empty", int'(bus.empty), 1);
    chk("t5_count", int'(bus.count), 0);
`ifdef UART_TX_FIFO_OVF_EN
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
`endif
    tx_lat = 30;
    base = n_launch;
    push(8'h40, 1);
    for (int i = 1; i < 5; i++) push(8'(8'h40 + i), 0);
    repeat (2) @(negedge clk);
    chk("t6_queued", int'(bus.count), 4);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_count", int'(bus.count), 0);
    chk("t6_rst_empty", int'(bus.empty), 1);
    chk("t6_rst_tx_start", int'(bus.tx_start), 0);
    reset_n = 1'b1;
    @(negedge clk);
    stray_req++;
    repeat (12) @(negedge clk);
    chk("t6_no_launch", n_launch - base, 1);
    chk("t6_count", int'(bus.count), 0);
    chk("t6_tx_data", int'(bus.tx_data), 0);
    chk("t6_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
